bus_fifo_bank: RTL and testbench

BUS_FIFO_BANK -- requirements
Module: bus_fifo_bank

---
 rtl/bus_fifo_bank_if.sv | 46 ++++
 rtl/bus_fifo_bank.sv | 154 +++++++++++++++
 tb/tb_bus_fifo_bank.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_fifo_bank_if.sv
// -----------------------------------------------------------------------------
// bus_fifo_bank_if
// Groups every per-channel handshake and data signal of bus_fifo_bank.
//   master : the environment side (testbench writer/reader and the bus model);
//            drives strobes and write data, observes status and head data.
//   slave  : the FIFO bank itself.
// Signals (i = channel, packets sliced as [i*PCKG_SZ +: PCKG_SZ]):
//   tx_wr/tx_data   write into TX FIFO i        tx_full/tx_count  TX status
//   pndng/D_pop     TX head presented to bus    pop               bus takes TX head
//   push/D_push     bus delivers into RX FIFO   rx_rd             read RX head
//   rx_valid/rx_data RX head                    ovf/udf           sticky errors
//   clr_err         clears every ovf/udf flag
// -----------------------------------------------------------------------------
interface bus_fifo_bank_if #(
    parameter int PCKG_SZ = 16,
    parameter int DRVRS   = 4,
    parameter int DEPTH   = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DRVRS-1:0]         tx_wr;
    logic [DRVRS*PCKG_SZ-1:0] tx_data;
    logic [DRVRS-1:0]         tx_full;
    logic [DRVRS-1:0]         pndng;
    logic [DRVRS*PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]         pop;
    logic [DRVRS-1:0]         push;
    logic [DRVRS*PCKG_SZ-1:0] D_push;
    logic [DRVRS-1:0]         rx_rd;
    logic [DRVRS-1:0]         rx_valid;
    logic [DRVRS*PCKG_SZ-1:0] rx_data;
    logic [DRVRS*CW-1:0]      tx_count;
    logic [DRVRS-1:0]         ovf;
    logic [DRVRS-1:0]         udf;
    logic                     clr_err;

    modport master (
        output tx_wr, tx_data, pop, push, D_push, rx_rd, clr_err,
        input  tx_full, pndng, D_pop, rx_valid, rx_data, tx_count, ovf, udf
    );

    modport slave (
        input  tx_wr, tx_data, pop, push, D_push, rx_rd, clr_err,
        output tx_full, pndng, D_pop, rx_valid, rx_data, tx_count, ovf, udf
    );
endinterface

// File: rtl/bus_fifo_bank.sv
// -----------------------------------------------------------------------------
// bus_fifo_bank
// DRVRS independent channels, each with a TX FIFO (testbench writes, bus pops)
// and an RX FIFO (bus pushes, testbench reads). Both FIFOs are show-ahead:
// the head entry is read combinationally from storage.
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous active-low reset (pointers, counts, error flags)
//   bus   : bus_fifo_bank_if.slave, all per-channel strobes/data/status
// -----------------------------------------------------------------------------

// One DEPTH x WIDTH show-ahead FIFO. Reports rejected accesses as single-cycle
// events; the bank turns them into sticky flags.
module bus_fifo_bank_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             ovf_evt,
    output logic             udf_evt
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    // A read only succeeds with data present. A write to a full FIFO still
    // succeeds when a read frees the head slot at the same edge; on an empty
    // FIFO the read fails but the write is still taken.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_rd    = rd_en && (count_q != '0);
        do_wr    = wr_en && ((count_q != CW'(DEPTH)) || do_rd);

        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;

        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by count, so stale entries are never visible as valid.
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign ovf_evt = wr_en && !do_wr;
    assign udf_evt = rd_en && !do_rd;
endmodule

module bus_fifo_bank #(
    parameter  int PCKG_SZ = 16,
    parameter  int DRVRS   = 4,
    parameter  int DEPTH   = 8,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input logic            clock,
    input logic            reset,
    bus_fifo_bank_if.slave bus
);
    logic [DRVRS-1:0] tx_ovf_evt, tx_udf_evt;
    logic [DRVRS-1:0] rx_ovf_evt, rx_udf_evt;
    logic [DRVRS-1:0] ovf_q, ovf_d;
    logic [DRVRS-1:0] udf_q, udf_d;
    logic [CW-1:0]    tx_cnt [DRVRS];
    logic [CW-1:0]    rx_cnt [DRVRS];

    for (genvar i = 0; i < DRVRS; i++) begin : g_ch
        bus_fifo_bank_fifo #(
            .WIDTH (PCKG_SZ),
            .DEPTH (DEPTH)
        ) u_tx (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (bus.tx_wr[i]),
            .wr_data (bus.tx_data[i*PCKG_SZ +: PCKG_SZ]),
            .rd_en   (bus.pop[i]),
            .rd_data (bus.D_pop[i*PCKG_SZ +: PCKG_SZ]),
            .count   (tx_cnt[i]),
            .ovf_evt (tx_ovf_evt[i]),
            .udf_evt (tx_udf_evt[i])
        );

        bus_fifo_bank_fifo #(
            .WIDTH (PCKG_SZ),
            .DEPTH (DEPTH)
        ) u_rx (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (bus.push[i]),
            .wr_data (bus.D_push[i*PCKG_SZ +: PCKG_SZ]),
            .rd_en   (bus.rx_rd[i]),
            .rd_data (bus.rx_data[i*PCKG_SZ +: PCKG_SZ]),
            .count   (rx_cnt[i]),
            .ovf_evt (rx_ovf_evt[i]),
            .udf_evt (rx_udf_evt[i])
        );

        // Status is decoded from the occupancy counters only.
        assign bus.tx_count[i*CW +: CW] = tx_cnt[i];
        assign bus.pndng[i]             = (tx_cnt[i] != '0);
        assign bus.tx_full[i]           = (tx_cnt[i] == CW'(DEPTH));
        assign bus.rx_valid[i]          = (rx_cnt[i] != '0);
    end

    // A new error at the same edge as clr_err wins, so no event is lost.
    always_comb begin
        ovf_d = (ovf_q & ~{DRVRS{bus.clr_err}}) | tx_ovf_evt | rx_ovf_evt;
        udf_d = (udf_q & ~{DRVRS{bus.clr_err}}) | tx_udf_evt | rx_udf_evt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
endmodule

// File: tb/tb_bus_fifo_bank.sv
module tb_bus_fifo_bank;
    localparam int PCKG_SZ = 16;
    localparam int DRVRS   = 4;
    localparam int DEPTH   = 8;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int DW      = DRVRS * PCKG_SZ;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    bus_fifo_bank_if #(.PCKG_SZ(PCKG_SZ), .DRVRS(DRVRS), .DEPTH(DEPTH)) bus ();

    bus_fifo_bank #(.PCKG_SZ(PCKG_SZ), .DRVRS(DRVRS), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: one queue per FIFO plus sticky flag vectors.
    logic [PCKG_SZ-1:0] tx_m [DRVRS][$];
    logic [PCKG_SZ-1:0] rx_m [DRVRS][$];
    logic [DRVRS-1:0]   ovf_m, udf_m;

    typedef struct {
        logic [DRVRS-1:0]    tx_wr;
        logic [DW-1:0]       tx_data;
        logic [DRVRS-1:0]    pop;
        logic [DRVRS-1:0]    push;
        logic [DW-1:0]       d_push;
        logic [DRVRS-1:0]    rx_rd;
        logic                clr_err;
        logic [DRVRS-1:0]    e_pndng;
        logic [DRVRS*CW-1:0] e_tx_count;
        logic [DW-1:0]       e_d_pop;
        logic [DRVRS-1:0]    e_rx_valid;
        logic [DW-1:0]       e_rx_data;
        logic [DRVRS-1:0]    e_ovf;
        logic [DRVRS-1:0]    e_udf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        bus.tx_wr   = '0;
        bus.tx_data = '0;
        bus.pop     = '0;
        bus.push    = '0;
        bus.D_push  = '0;
        bus.rx_rd   = '0;
        bus.clr_err = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DRVRS; i++) begin
            tx_m[i].delete();
            rx_m[i].delete();
        end
        ovf_m = '0;
        udf_m = '0;
    endtask

    // Applies the currently driven strobes to the model (called just before the edge).
    task automatic model_step();
        logic [DRVRS-1:0] ovf_ev, udf_ev;
        ovf_ev = '0;
        udf_ev = '0;
        for (int i = 0; i < DRVRS; i++) begin
            bit rd_ok, wr_ok;
            rd_ok = bus.pop[i] && (tx_m[i].size() > 0);
            wr_ok = bus.tx_wr[i] && ((tx_m[i].size() < DEPTH) || rd_ok);
            if (bus.pop[i] && !rd_ok) udf_ev[i] = 1'b1;
            if (bus.tx_wr[i] && !wr_ok) ovf_ev[i] = 1'b1;
            if (rd_ok) void'(tx_m[i].pop_front());
            if (wr_ok) tx_m[i].push_back(bus.tx_data[i*PCKG_SZ +: PCKG_SZ]);

            rd_ok = bus.rx_rd[i] && (rx_m[i].size() > 0);
            wr_ok = bus.push[i] && ((rx_m[i].size() < DEPTH) || rd_ok);
            if (bus.rx_rd[i] && !rd_ok) udf_ev[i] = 1'b1;
            if (bus.push[i] && !wr_ok) ovf_ev[i] = 1'b1;
            if (rd_ok) void'(rx_m[i].pop_front());
            if (wr_ok) rx_m[i].push_back(bus.D_push[i*PCKG_SZ +: PCKG_SZ]);
        end
        ovf_m = (ovf_m & ~{DRVRS{bus.clr_err}}) | ovf_ev;
        udf_m = (udf_m & ~{DRVRS{bus.clr_err}}) | udf_ev;
    endtask

    task automatic compare_all();
        for (int i = 0; i < DRVRS; i++) begin
            check($sformatf("pndng[%0d]", i),    bus.pndng[i],    tx_m[i].size() != 0);
            check($sformatf("tx_full[%0d]", i),  bus.tx_full[i],  tx_m[i].size() == DEPTH);
            check($sformatf("tx_count[%0d]", i), bus.tx_count[i*CW +: CW], tx_m[i].size());
            check($sformatf("rx_valid[%0d]", i), bus.rx_valid[i], rx_m[i].size() != 0);
            check($sformatf("ovf[%0d]", i),      bus.ovf[i],      ovf_m[i]);
            check($sformatf("udf[%0d]", i),      bus.udf[i],      udf_m[i]);
            if (tx_m[i].size() > 0)
                check($sformatf("D_pop[%0d]", i), bus.D_pop[i*PCKG_SZ +: PCKG_SZ], tx_m[i][0]);
            if (rx_m[i].size() > 0)
                check($sformatf("rx_data[%0d]", i), bus.rx_data[i*PCKG_SZ +: PCKG_SZ], rx_m[i][0]);
        end
    endtask

    // One clock: update model, take the edge, sample 1 time unit later, drop strobes.
    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
        clear_inputs();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pndng"},    bus.pndng,    '0);
        check({tag, "_rx_valid"}, bus.rx_valid, '0);
        check({tag, "_tx_full"},  bus.tx_full,  '0);
        check({tag, "_tx_count"}, bus.tx_count, '0);
        check({tag, "_ovf"},      bus.ovf,      '0);
        check({tag, "_udf"},      bus.udf,      '0);
    endtask

    // Reset pulse placed between edges; outputs must clear with no clock.
    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        check_zero(tag);
        #2;
        reset = 1'b1;
    endtask

    function automatic logic [DW-1:0] mask_heads(input logic [DW-1:0] d, input logic [DRVRS-1:0] v);
        for (int i = 0; i < DRVRS; i++)
            if (!v[i]) d[i*PCKG_SZ +: PCKG_SZ] = '0;
        return d;
    endfunction

    function automatic vec_t mk(input logic [DRVRS-1:0] tx_wr, input logic [DW-1:0] tx_data,
                                input logic [DRVRS-1:0] pop, input logic [DRVRS-1:0] push,
                                input logic [DW-1:0] d_push, input logic [DRVRS-1:0] rx_rd,
                                input logic clr, input logic [DRVRS-1:0] e_pndng,
                                input logic [DRVRS*CW-1:0] e_cnt, input logic [DW-1:0] e_dpop,
                                input logic [DRVRS-1:0] e_rxv, input logic [DW-1:0] e_rxd,
                                input logic [DRVRS-1:0] e_ovf, input logic [DRVRS-1:0] e_udf);
        vec_t v;
        v.tx_wr = tx_wr;   v.tx_data = tx_data; v.pop = pop;     v.push = push;
        v.d_push = d_push; v.rx_rd = rx_rd;     v.clr_err = clr; v.e_pndng = e_pndng;
        v.e_tx_count = e_cnt; v.e_d_pop = e_dpop; v.e_rx_valid = e_rxv;
        v.e_rx_data = e_rxd;  v.e_ovf = e_ovf;    v.e_udf = e_udf;
        return v;
    endfunction

    initial begin
        logic [PCKG_SZ-1:0] last;

        // Vectors from a clean reset; expected values written out by hand.
        vecs[0] = mk(4'b0001, 64'h0000_0000_0000_A5A5, 4'b0000, 4'b0000, 64'h0, 4'b0000, 1'b0,
                     4'b0001, 16'h0001, 64'h0000_0000_0000_A5A5, 4'b0000, 64'h0, 4'b0000, 4'b0000);
        vecs[1] = mk(4'b0000, 64'h0, 4'b0000, 4'b1111, 64'h1003_1002_1001_1000, 4'b0000, 1'b0,
                     4'b0001, 16'h0001, 64'h0000_0000_0000_A5A5, 4'b1111, 64'h1003_1002_1001_1000, 4'b0000, 4'b0000);
        vecs[2] = mk(4'b0000, 64'h0, 4'b0001, 4'b0000, 64'h0, 4'b0000, 1'b0,
                     4'b0000, 16'h0000, 64'h0, 4'b1111, 64'h1003_1002_1001_1000, 4'b0000, 4'b0000);
        vecs[3] = mk(4'b0000, 64'h0, 4'b1000, 4'b0000, 64'h0, 4'b0000, 1'b0,
                     4'b0000, 16'h0000, 64'h0, 4'b1111, 64'h1003_1002_1001_1000, 4'b0000, 4'b1000);
        vecs[4] = mk(4'b0000, 64'h0, 4'b1000, 4'b0000, 64'h0, 4'b0000, 1'b1,
                     4'b0000, 16'h0000, 64'h0, 4'b1111, 64'h1003_1002_1001_1000, 4'b0000, 4'b1000);
        vecs[5] = mk(4'b0000, 64'h0, 4'b0000, 4'b0000, 64'h0, 4'b0000, 1'b1,
                     4'b0000, 16'h0000, 64'h0, 4'b1111, 64'h1003_1002_1001_1000, 4'b0000, 4'b0000);
        vecs[6] = mk(4'b0000, 64'h0, 4'b0000, 4'b0000, 64'h0, 4'b1111, 1'b0,
                     4'b0000, 16'h0000, 64'h0, 4'b0000, 64'h0, 4'b0000, 4'b0000);
        vecs[7] = mk(4'b0000, 64'h0, 4'b0000, 4'b0010, 64'h0000_0000_2222_0000, 4'b0010, 1'b0,
                     4'b0000, 16'h0000, 64'h0, 4'b0010, 64'h0000_0000_2222_0000, 4'b0000, 4'b0010);
        vecs[8] = mk(4'b0100, 64'h0000_3333_0000_0000, 4'b0100, 4'b0000, 64'h0, 4'b0000, 1'b0,
                     4'b0100, 16'h0100, 64'h0000_3333_0000_0000, 4'b0010, 64'h0000_0000_2222_0000, 4'b0000, 4'b0110);
        vecs[9] = mk(4'b0100, 64'h0000_4444_0000_0000, 4'b0000, 4'b0000, 64'h0, 4'b0000, 1'b1,
                     4'b0100, 16'h0200, 64'h0000_3333_0000_0000, 4'b0010, 64'h0000_0000_2222_0000, 4'b0000, 4'b0000);

        clear_inputs();
        model_reset();
        #2;
        check_zero("por");
        #5;
        reset = 1'b1;

        // Table-driven vectors.
        for (int v = 0; v < 10; v++) begin
            bus.tx_wr   = vecs[v].tx_wr;
            bus.tx_data = vecs[v].tx_data;
            bus.pop     = vecs[v].pop;
            bus.push    = vecs[v].push;
            bus.D_push  = vecs[v].d_push;
            bus.rx_rd   = vecs[v].rx_rd;
            bus.clr_err = vecs[v].clr_err;
            cycle();
            check($sformatf("vec%0d_pndng", v),    bus.pndng,    vecs[v].e_pndng);
            check($sformatf("vec%0d_tx_count", v), bus.tx_count, vecs[v].e_tx_count);
            check($sformatf("vec%0d_d_pop", v),    mask_heads(bus.D_pop, bus.pndng), vecs[v].e_d_pop);
            check($sformatf("vec%0d_rx_valid", v), bus.rx_valid, vecs[v].e_rx_valid);
            check($sformatf("vec%0d_rx_data", v),  mask_heads(bus.rx_data, bus.rx_valid), vecs[v].e_rx_data);
            check($sformatf("vec%0d_ovf", v),      bus.ovf,      vecs[v].e_ovf);
            check($sformatf("vec%0d_udf", v),      bus.udf,      vecs[v].e_udf);
        end

        // Fill TX FIFO 2, overflow it, then drain in order.
        pulse_reset("rst_a");
        for (int k = 1; k <= DEPTH; k++) begin
            bus.tx_wr[2] = 1'b1;
            bus.tx_data[2*PCKG_SZ +: PCKG_SZ] = PCKG_SZ'(k);
            cycle();
        end
        check("full2_tx_full", bus.tx_full[2], 1'b1);
        bus.tx_wr[2] = 1'b1;
        bus.tx_data[2*PCKG_SZ +: PCKG_SZ] = 16'h0009;
        cycle();
        check("full2_ovf", bus.ovf[2], 1'b1);
        check("full2_count", bus.tx_count[2*CW +: CW], DEPTH);
        for (int k = 1; k <= DEPTH; k++) begin
            check($sformatf("drain2_%0d", k), bus.D_pop[2*PCKG_SZ +: PCKG_SZ], k);
            bus.pop[2] = 1'b1;
            cycle();
        end
        check("drain2_pndng", bus.pndng[2], 1'b0);

        // Write and pop together on a full TX FIFO 1.
        pulse_reset("rst_b");
        for (int k = 0; k < DEPTH; k++) begin
            bus.tx_wr[1] = 1'b1;
            bus.tx_data[1*PCKG_SZ +: PCKG_SZ] = PCKG_SZ'(16'h0010 + k);
            cycle();
        end
        bus.tx_wr[1] = 1'b1;
        bus.pop[1]   = 1'b1;
        bus.tx_data[1*PCKG_SZ +: PCKG_SZ] = 16'h00FF;
        cycle();
        check("fullrw_count", bus.tx_count[1*CW +: CW], DEPTH);
        check("fullrw_ovf", bus.ovf[1], 1'b0);
        last = '0;
        for (int k = 0; k < DEPTH; k++) begin
            last = bus.D_pop[1*PCKG_SZ +: PCKG_SZ];
            bus.pop[1] = 1'b1;
            cycle();
        end
        check("fullrw_last", last, 16'h00FF);
        check("fullrw_empty", bus.pndng[1], 1'b0);

        // Reset mid-stream with 5 entries queued on channel 0.
        pulse_reset("rst_c");
        for (int k = 0; k < 5; k++) begin
            bus.tx_wr[0] = 1'b1;
            bus.tx_data[0 +: PCKG_SZ] = PCKG_SZ'(16'h0500 + k);
            bus.push[0] = 1'b1;
            bus.D_push[0 +: PCKG_SZ] = PCKG_SZ'(16'h0600 + k);
            cycle();
        end
        pulse_reset("rst_mid");
        bus.tx_wr[0] = 1'b1;
        bus.tx_data[0 +: PCKG_SZ] = 16'hBEEF;
        cycle();
        check("post_rst_head", bus.D_pop[0 +: PCKG_SZ], 16'hBEEF);
        check("post_rst_count", bus.tx_count[0 +: CW], 1);
        bus.pop[0] = 1'b1;
        cycle();
        check("post_rst_empty", bus.pndng[0], 1'b0);
        check("post_rst_rx", bus.rx_valid[0], 1'b0);

        // Randomized traffic; phases alternate between filling and draining.
        pulse_reset("rst_r");
        for (int c = 0; c < 600; c++) begin
            int wr_pct, rd_pct;
            wr_pct = ((c / 75) % 2 == 0) ? 75 : 30;
            rd_pct = ((c / 75) % 2 == 0) ? 30 : 75;
            for (int i = 0; i < DRVRS; i++) begin
                bus.tx_wr[i] = ($urandom_range(99) < wr_pct);
                bus.pop[i]   = ($urandom_range(99) < rd_pct);
                bus.push[i]  = ($urandom_range(99) < wr_pct);
                bus.rx_rd[i] = ($urandom_range(99) < rd_pct);
                bus.tx_data[i*PCKG_SZ +: PCKG_SZ] = PCKG_SZ'($urandom);
                bus.D_push[i*PCKG_SZ +: PCKG_SZ]  = PCKG_SZ'($urandom);
            end
            bus.clr_err = ($urandom_range(15) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
